ds_tx_arbiter: RTL and testbench
================================

# ds_tx_arbiter

Round-robin, packet-locked arbiter that shares one horizontal NAP data-stream transmit interface among NUM_REQ requester modules. It sits between several sender-style modules and a single `nap_horizontal_wrapper` tx port. It grants one requester at a time and holds the grant from the start-of-packet beat through the end-of-packet beat. It forwards beats through a one-stage output register.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, `ACX_NAP_HORIZONTAL_DATA_WIDTH`, beat payload width
- ADDR_WIDTH, `ACX_NAP_DS_ADDR_WIDTH`, destination address width
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  sole clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_ready  out  NUM_REQ  per-requester beat accept; at most one bit high
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_addr  in  NUM_REQ*ADDR_WIDTH  destination (NoC column), packed the same way
- req_sop  in  NUM_REQ  first beat of packet
- req_eop  in  NUM_REQ  last beat of packet; sop and eop both high = single-beat packet
- nap_valid  out  1  beat valid to NAP tx
- nap_ready  in  1  NAP tx accept
- nap_data  out  DATA_WIDTH  beat payload
- nap_addr  out  ADDR_WIDTH  beat destination
- nap_sop  out  1  start of packet
- nap_eop  out  1  end of packet
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester
- busy  out  1  high while in LOCKED
- err_nosop  out  1  sticky; set when a non-granted requester asserts valid without sop in IDLE

## Operation
- State machine has two states, IDLE and LOCKED.
- IDLE: a requester is eligible when req_valid[i] & req_sop[i]. The arbiter picks the first eligible index, searching from ptr upward with wrap. It registers grant_id and moves to LOCKED. req_ready is all-zero in IDLE.
- IDLE with no eligible requester: remains in IDLE. Any req_valid without sop sets err_nosop, which stays set until reset. That beat is never accepted.
- LOCKED: req_ready[grant_id] = out_free, where out_free = !nap_valid | nap_ready. All other req_ready bits are 0.
- A beat is accepted when req_valid[g] & req_ready[g]. On acceptance, data, addr, sop and eop are loaded into the output register and nap_valid is set.
- Accepting a beat with eop=1 returns to IDLE and sets ptr = grant_id+1 mod NUM_REQ.
- The granted requester may drop valid mid-packet. The arbiter stays LOCKED indefinitely; there is no timeout.
- Output register: nap_* is held stable while nap_valid & !nap_ready. nap_valid clears when nap_ready is high and no new beat is loaded that cycle.
- Beats are passed through unmodified, including per-beat addr. Packet content is never inspected or modified.

## Timing
- Reset state: state=IDLE, ptr=0, grant_id=0, busy=0, err_nosop=0, nap_valid=0, nap_sop=0, nap_eop=0, nap_data=0, nap_addr=0, req_ready=0.
- Arbitration latency: one cycle in IDLE before the first beat can be accepted.
- Beat latency: an input handshake in cycle N gives nap_valid in cycle N+1.
- Throughput: one beat per cycle inside a packet while nap_ready=1.
- Packet overhead: exactly one IDLE bubble between consecutive packets.
- Backpressure: if nap_ready=0 while nap_valid=1, req_ready drops in the same cycle (combinational path from nap_ready).
- Single-beat packet: LOCKED lasts exactly one accepting cycle.
- Simultaneous requests: only one grant per IDLE cycle. Losers keep valid high and are served in later rounds in round-robin order.
- Reset mid-packet: the output beat is discarded without completing its NAP handshake. The partial packet is not resumed.

## Test plan
- Single requester 0 sends a 3-beat packet, addr=2, nap_ready=1 → nap_valid in cycles 2,3,4 after valid; sop on beat 0, eop on beat 2; busy high for 3 cycles; grant_id=0.
- All 4 requesters hold 2-beat packets continuously → grant order 0,1,2,3,0,…; no beat interleaving between packets; one bubble per packet boundary.
- Requester 1 mid-packet with nap_ready toggling 1,0,0,1 → nap_* stable while stalled; req_ready[1] low during the stall; no beat dropped or duplicated.
- Requester 2 asserts valid with sop=0 while IDLE → err_nosop=1 and stays 1; req_ready[2] stays 0; later valid packets from other requesters flow normally.
- Reset asserted during beat 2 of a 4-beat packet → next cycle nap_valid=0, busy=0, ptr=0; a new packet from requester 3 is granted normally.
- Single-beat packets (sop=eop=1) from requesters 0 and 3 simultaneously → requester 0 is served first, then requester 3; two nap beats, each with sop=eop=1.

Source files
------------

// File: rtl/ds_tx_arbiter_if.sv
// Requester and NAP tx beat bus for ds_tx_arbiter.
// slave = arbiter side, master = requesters plus NAP sink.
`ifndef ACX_NAP_HORIZONTAL_DATA_WIDTH
`define ACX_NAP_HORIZONTAL_DATA_WIDTH 256
`endif
`ifndef ACX_NAP_DS_ADDR_WIDTH
`define ACX_NAP_DS_ADDR_WIDTH 4
`endif

interface ds_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = `ACX_NAP_HORIZONTAL_DATA_WIDTH,
  parameter int ADDR_WIDTH = `ACX_NAP_DS_ADDR_WIDTH
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_sop;
  logic [NUM_REQ-1:0]            req_eop;

  logic                  nap_valid;
  logic                  nap_ready;
  logic [DATA_WIDTH-1:0] nap_data;
  logic [ADDR_WIDTH-1:0] nap_addr;
  logic                  nap_sop;
  logic                  nap_eop;

  modport slave (
    input  req_valid, req_data, req_addr,
    input  req_sop, req_eop, nap_ready,
    output req_ready, nap_valid, nap_data,
    output nap_addr, nap_sop, nap_eop
  );

  modport master (
    output req_valid, req_data, req_addr,
    output req_sop, req_eop, nap_ready,
    input  req_ready, nap_valid, nap_data,
    input  nap_addr, nap_sop, nap_eop
  );
endinterface

// File: rtl/ds_tx_arbiter.sv
// Round-robin packet-locked arbiter sharing one NAP ds tx port.
// Grant holds sop..eop; beats go through one output register.
`ifndef ACX_NAP_HORIZONTAL_DATA_WIDTH
`define ACX_NAP_HORIZONTAL_DATA_WIDTH 256
`endif
`ifndef ACX_NAP_DS_ADDR_WIDTH
`define ACX_NAP_DS_ADDR_WIDTH 4
`endif

module ds_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = `ACX_NAP_HORIZONTAL_DATA_WIDTH,
  parameter int ADDR_WIDTH = `ACX_NAP_DS_ADDR_WIDTH,
  localparam int IW        = $clog2(NUM_REQ)
) (
  input  logic          clk,
  input  logic          reset,
  ds_tx_arbiter_if.slave bus,
  output logic [IW-1:0] grant_id,
  output logic          busy,
  output logic          err_nosop
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e                state_q;
  logic [IW-1:0]         ptr_q;
  logic [IW-1:0]         ptr_d;
  logic [IW-1:0]         grant_q;
  logic                  err_q;
  logic                  vld_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  sop_q;
  logic                  eop_q;

  logic [NUM_REQ-1:0]    elig;
  logic                  pick_vld;
  logic [IW-1:0]         pick_idx;
  logic                  out_free;
  logic                  g_valid;
  logic                  accept;
  logic                  nosop;
  logic [NUM_REQ-1:0]    ready;

  assign elig     = bus.req_valid & bus.req_sop;
  assign out_free = !vld_q || bus.nap_ready;
  assign g_valid  = bus.req_valid[grant_q];
  assign accept   = (state_q == LOCKED)
                 && g_valid && out_free;
  assign nosop    = |(bus.req_valid & ~bus.req_sop);
  assign ptr_d    = (grant_q == IW'(NUM_REQ-1))
                  ? '0 : grant_q + IW'(1);

  // First eligible requester searching upward from ptr, with wrap.
  always_comb begin
    logic [IW:0] sum;
    pick_vld = 1'b0;
    pick_idx = '0;
    sum      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ))
        sum = sum - (IW+1)'(NUM_REQ);
      if (!pick_vld && elig[sum[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    ready = '0;
    if (state_q == LOCKED)
      ready[grant_q] = out_free;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      if (accept) begin
        vld_q  <= 1'b1;
        data_q <= bus.req_data[
                    int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        addr_q <= bus.req_addr[
                    int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
        sop_q  <= bus.req_sop[grant_q];
        eop_q  <= bus.req_eop[grant_q];
      end else if (bus.nap_ready) begin
        vld_q  <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (nosop)
            err_q <= 1'b1;
          if (pick_vld) begin
            grant_q <= pick_idx;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept && bus.req_eop[grant_q]) begin
            state_q <= IDLE;
            ptr_q   <= ptr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.nap_valid = vld_q;
  assign bus.nap_data  = data_q;
  assign bus.nap_addr  = addr_q;
  assign bus.nap_sop   = sop_q;
  assign bus.nap_eop   = eop_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q == LOCKED);
  assign err_nosop     = err_q;

endmodule

// File: tb/tb_ds_tx_arbiter.sv
// Bench for ds_tx_arbiter: queued requester drivers,
// expected beats in a scoreboard checked by a NAP monitor.
module tb_ds_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic          err_nosop;

  ds_tx_arbiter_if #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) bus ();

  ds_tx_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .reset    (rst),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy),
    .err_nosop(err_nosop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic          s;
    logic          e;
  } beat_t;

  typedef struct packed {
    beat_t         b;
    logic [IW-1:0] g;
    logic          chk_g;
    int            gap;
  } exp_t;

  beat_t rq[NR][$];
  exp_t  sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    fires = 0;
  int    last_fire = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic beat_t mk(int r, int p, int i,
                               int a, bit s, bit e);
    beat_t b;
    b.d = {8'(r), 8'(p), 8'(i), 8'h5a};
    b.a = AW'(a);
    b.s = s;
    b.e = e;
    return b;
  endfunction

  task automatic send_pkt(int r, int p, int n, int a);
    for (int i = 0; i < n; i++)
      rq[r].push_back(mk(r, p, i, a, i == 0, i == n-1));
  endtask

  task automatic expect_pkt(int r, int p, int n, int cnt,
                            int a, int gap0, int gapn);
    exp_t x;
    for (int i = 0; i < cnt; i++) begin
      x.b     = mk(r, p, i, a, i == 0, i == n-1);
      x.g     = IW'(r);
      x.chk_g = (i == 0);
      x.gap   = (i == 0) ? gap0 : gapn;
      sb.push_back(x);
    end
  endtask

  task automatic wait_drain(input logic [NR-1:0] mask);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      done = (sb.size() == 0);
      for (int i = 0; i < NR; i++)
        if (mask[i] && rq[i].size() != 0) done = 1'b0;
    end
    chk("drain", 64'(done), 64'(1));
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_fire(input int n);
    for (int t = 0; t < 100 && fires < n; t++)
      @(negedge clk);
    chk("fire_wait", 64'(fires >= n), 64'(1));
  endtask

  // Requester drivers: present queue heads, pop on handshake.
  initial begin
    logic [NR-1:0] fire;
    beat_t b;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_addr  = '0;
    bus.req_sop   = '0;
    bus.req_eop   = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (rq[i].size() > 0) begin
          b = rq[i][0];
          bus.req_valid[i] = 1'b1;
          bus.req_data[i*DW +: DW] = b.d;
          bus.req_addr[i*AW +: AW] = b.a;
          bus.req_sop[i] = b.s;
          bus.req_eop[i] = b.e;
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_sop[i]   = 1'b0;
          bus.req_eop[i]   = 1'b0;
        end
      end
      #4;
      fire = bus.req_valid & bus.req_ready;
      @(posedge clk);
      for (int i = 0; i < NR; i++)
        if (fire[i] && !rst && rq[i].size() > 0)
          void'(rq[i].pop_front());
    end
  end

  // NAP-side monitor and scoreboard checker.
  initial begin
    bit    prev_stall;
    beat_t prev_out;
    beat_t cur;
    exp_t  x;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      cur = {bus.nap_data, bus.nap_addr,
             bus.nap_sop, bus.nap_eop};
      if (!rst) begin
        chk("ready_onehot",
            64'($countones(bus.req_ready) <= 1), 64'(1));
        if (prev_stall)
          chk("stall_hold", 64'(cur), 64'(prev_out));
        if (bus.nap_valid && !bus.nap_ready)
          chk("ready_in_stall", 64'(bus.req_ready), 64'(0));
        if (bus.nap_valid && bus.nap_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", 64'(cur), 64'(0));
          end else begin
            x = sb.pop_front();
            chk("beat", 64'(cur), 64'(x.b));
            if (x.chk_g)
              chk("grant_id", 64'(grant_id), 64'(x.g));
            if (x.gap != 0)
              chk("gap", 64'(cyc - last_fire), 64'(x.gap));
          end
          last_fire = cyc;
          fires++;
        end
        prev_stall = bus.nap_valid && !bus.nap_ready;
        prev_out   = cur;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    bus.nap_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    chk("rst_nap_valid", 64'(bus.nap_valid), 64'(0));
    chk("rst_nap_sop", 64'(bus.nap_sop), 64'(0));
    chk("rst_nap_eop", 64'(bus.nap_eop), 64'(0));
    chk("rst_nap_data", 64'(bus.nap_data), 64'(0));
    chk("rst_nap_addr", 64'(bus.nap_addr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err_nosop), 64'(0));
    chk("rst_grant", 64'(grant_id), 64'(0));
    chk("rst_ready", 64'(bus.req_ready), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All four requesters, two 2-beat packets each.
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < NR; r++) begin
        send_pkt(r, p, 2, r + 4);
        expect_pkt(r, p, 2, 2, r + 4,
                   (p == 0 && r == 0) ? 0 : 2, 1);
      end
    wait_drain(4'hF);

    // Requester 0 alone, 3 beats to addr 2.
    @(posedge clk);
    #1;
    send_pkt(0, 4, 3, 2);
    expect_pkt(0, 4, 3, 3, 2, 0, 1);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      #4;
      if (busy) n++;
    end
    chk("busy_cycles", 64'(n), 64'(3));
    chk("grant_after_p1", 64'(grant_id), 64'(0));
    wait_drain(4'hF);

    // Requester 1 with nap_ready 1,0,0,1 mid-packet.
    @(posedge clk);
    #1;
    send_pkt(1, 0, 4, 1);
    expect_pkt(1, 0, 4, 4, 1, 0, 0);
    base = fires;
    wait_fire(base + 1);
    bus.nap_ready = 1'b0;
    repeat (2) @(negedge clk);
    bus.nap_ready = 1'b1;
    wait_drain(4'hF);

    // Requester 2 valid without sop in IDLE.
    @(posedge clk);
    #1;
    rq[2].push_back(mk(2, 0, 0, 9, 1'b0, 1'b0));
    n = 0;
    repeat (4) begin
      @(negedge clk);
      #4;
      if (bus.req_ready[2]) n++;
    end
    chk("nosop_ready2", 64'(n), 64'(0));
    chk("err_set", 64'(err_nosop), 64'(1));
    send_pkt(0, 1, 2, 3);
    expect_pkt(0, 1, 2, 2, 3, 0, 1);
    wait_drain(4'b1011);
    chk("err_sticky", 64'(err_nosop), 64'(1));
    chk("nosop_pending", 64'(rq[2].size()), 64'(1));
    @(posedge clk);
    #1;
    rq[2].delete();
    repeat (2) @(negedge clk);
    chk("err_still", 64'(err_nosop), 64'(1));

    // Reset during a 4-beat packet from requester 0.
    @(posedge clk);
    #1;
    send_pkt(0, 2, 4, 5);
    expect_pkt(0, 2, 4, 1, 5, 0, 1);
    base = fires;
    wait_fire(base + 1);
    rst = 1'b1;
    bus.nap_ready = 1'b0;
    rq[0].delete();
    @(negedge clk);
    #4;
    chk("mid_rst_valid", 64'(bus.nap_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_err", 64'(err_nosop), 64'(0));
    chk("mid_rst_grant", 64'(grant_id), 64'(0));
    chk("mid_rst_ready", 64'(bus.req_ready), 64'(0));
    chk("mid_rst_sb", 64'(sb.size()), 64'(0));
    rst = 1'b0;
    bus.nap_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Fresh packet from requester 3 after reset.
    @(posedge clk);
    #1;
    send_pkt(3, 0, 2, 6);
    expect_pkt(3, 0, 2, 2, 6, 0, 1);
    wait_drain(4'hF);

    // Simultaneous single-beat packets from 0 and 3.
    @(posedge clk);
    #1;
    send_pkt(0, 3, 1, 7);
    send_pkt(3, 1, 1, 8);
    expect_pkt(0, 3, 1, 1, 7, 0, 1);
    expect_pkt(3, 1, 1, 1, 8, 2, 1);
    wait_drain(4'hF);
    chk("final_busy", 64'(busy), 64'(0));
    chk("final_valid", 64'(bus.nap_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
